// File: rtl/decode_issue_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : decode_issue_if
// Purpose  : Fetch, register-file, writeback and ID/EX signals of the decode/issue stage
// Revision : 1.0
// ----------------------------------------------------------------------------
interface decode_issue_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_instr;
  logic [XLEN-1:0]  in_pc;
  logic [4:0]       rf_read_reg_1;
  logic [4:0]       rf_read_reg_2;
  logic [XLEN-1:0]  rf_read_data_1;
  logic [XLEN-1:0]  rf_read_data_2;
  logic             wb_en;
  logic [4:0]       wb_reg;
  logic [XLEN-1:0]  wb_data;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_pc;
  logic [2:0]       out_op;
  logic [XLEN-1:0]  out_rs_val;
  logic [XLEN-1:0]  out_rt_val;
  logic [XLEN-1:0]  out_imm;
  logic [5:0]       out_funct;
  logic [4:0]       out_dest;
  logic             out_reg_write;
  logic             out_illegal;
  logic [NREGS-1:0] busy_bits;

  modport slave (
    input  in_valid, in_instr, in_pc, rf_read_data_1, rf_read_data_2,
           wb_en, wb_reg, wb_data, out_ready,
    output in_ready, rf_read_reg_1, rf_read_reg_2, out_valid, out_pc, out_op,
           out_rs_val, out_rt_val, out_imm, out_funct, out_dest,
           out_reg_write, out_illegal, busy_bits
  );

  modport master (
    output in_valid, in_instr, in_pc, rf_read_data_1, rf_read_data_2,
           wb_en, wb_reg, wb_data, out_ready,
    input  in_ready, rf_read_reg_1, rf_read_reg_2, out_valid, out_pc, out_op,
           out_rs_val, out_rt_val, out_imm, out_funct, out_dest,
           out_reg_write, out_illegal, busy_bits
  );
endinterface
`default_nettype wire

// File: rtl/decode_issue_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : decode_issue_stage
// Purpose  : Decode, scoreboard hazard stall and ID/EX slot; DECODE_WB_BYPASS_EN adds writeback bypass
// Revision : 1.0
// ----------------------------------------------------------------------------
module decode_issue_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  wire logic     clk,
  input  wire logic     reset,
  decode_issue_if.slave io
);
  localparam logic [5:0] c_OPC_RTYPE = 6'h00;
  localparam logic [5:0] c_OPC_ADDI  = 6'h08;
  localparam logic [5:0] c_OPC_LW    = 6'h23;
  localparam logic [5:0] c_OPC_SW    = 6'h2B;
  localparam logic [5:0] c_OPC_BEQ   = 6'h04;

  logic [5:0]       w_opc;
  logic [4:0]       w_rs, w_rt, w_rd;
  logic [2:0]       w_op;
  logic             w_use_rs, w_use_rt, w_wr, w_illegal;
  logic [4:0]       w_dest;
  logic             w_reg_write;
  logic             w_wb_hit_rs, w_wb_hit_rt, w_wb_hit_dest;
  logic             w_rs_busy, w_rt_busy, w_waw, w_hazard, w_fire;
  logic [XLEN-1:0]  w_rs_val, w_rt_val;
  logic [NREGS-1:0] w_busy_next;

  logic [NREGS-1:0] r_busy;
  logic             r_out_valid;
  logic [XLEN-1:0]  r_out_pc, r_out_rs_val, r_out_rt_val, r_out_imm;
  logic [2:0]       r_out_op;
  logic [5:0]       r_out_funct;
  logic [4:0]       r_out_dest;
  logic             r_out_reg_write, r_out_illegal;

  assign w_opc = io.in_instr[31:26];
  assign w_rs  = io.in_instr[25:21];
  assign w_rt  = io.in_instr[20:16];
  assign w_rd  = io.in_instr[15:11];

  assign io.rf_read_reg_1 = w_rs;
  assign io.rf_read_reg_2 = w_rt;

  always_comb begin
    w_op      = 3'd7;
    w_use_rs  = 1'b0;
    w_use_rt  = 1'b0;
    w_wr      = 1'b0;
    w_dest    = 5'd0;
    w_illegal = 1'b0;
    case (w_opc)
      c_OPC_RTYPE: begin w_op = 3'd0; w_use_rs = 1'b1; w_use_rt = 1'b1; w_wr = 1'b1; w_dest = w_rd; end
      c_OPC_ADDI:  begin w_op = 3'd1; w_use_rs = 1'b1; w_wr = 1'b1; w_dest = w_rt; end
      c_OPC_LW:    begin w_op = 3'd2; w_use_rs = 1'b1; w_wr = 1'b1; w_dest = w_rt; end
      c_OPC_SW:    begin w_op = 3'd3; w_use_rs = 1'b1; w_use_rt = 1'b1; end
      c_OPC_BEQ:   begin w_op = 3'd4; w_use_rs = 1'b1; w_use_rt = 1'b1; end
      default:     w_illegal = 1'b1;
    endcase
  end

  // r0 is a constant: writing it is not a real write and never sets a busy bit
  assign w_reg_write = w_wr && (w_dest != 5'd0);

`ifdef DECODE_WB_BYPASS_EN
  assign w_wb_hit_rs   = io.wb_en && (io.wb_reg != 5'd0) && (io.wb_reg == w_rs);
  assign w_wb_hit_rt   = io.wb_en && (io.wb_reg != 5'd0) && (io.wb_reg == w_rt);
  assign w_wb_hit_dest = io.wb_en && (io.wb_reg != 5'd0) && (io.wb_reg == w_dest);
  assign w_rs_val      = w_wb_hit_rs ? io.wb_data : io.rf_read_data_1;
  assign w_rt_val      = w_wb_hit_rt ? io.wb_data : io.rf_read_data_2;
`else
  assign w_wb_hit_rs   = 1'b0;
  assign w_wb_hit_rt   = 1'b0;
  assign w_wb_hit_dest = 1'b0;
  assign w_rs_val      = io.rf_read_data_1;
  assign w_rt_val      = io.rf_read_data_2;
  logic w_unused_wb_data;
  assign w_unused_wb_data = ^io.wb_data;
`endif

  assign w_rs_busy = w_use_rs && r_busy[w_rs] && !w_wb_hit_rs;
  assign w_rt_busy = w_use_rt && r_busy[w_rt] && !w_wb_hit_rt;
  assign w_waw     = w_reg_write && r_busy[w_dest] && !w_wb_hit_dest;
  assign w_hazard  = io.in_valid && (w_rs_busy || w_rt_busy || w_waw);

  assign io.in_ready = !reset && !w_hazard && (!r_out_valid || io.out_ready);
  assign w_fire      = io.in_valid && io.in_ready;

  // Clear first so that a same-cycle set of the same register wins
  always_comb begin
    w_busy_next = r_busy;
    if (io.wb_en && (io.wb_reg != 5'd0))
      w_busy_next[io.wb_reg] = 1'b0;
    if (w_fire && w_reg_write)
      w_busy_next[w_dest] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy          <= '0;
      r_out_valid     <= 1'b0;
      r_out_pc        <= '0;
      r_out_rs_val    <= '0;
      r_out_rt_val    <= '0;
      r_out_imm       <= '0;
      r_out_op        <= 3'd0;
      r_out_funct     <= 6'd0;
      r_out_dest      <= 5'd0;
      r_out_reg_write <= 1'b0;
      r_out_illegal   <= 1'b0;
    end else begin
      r_busy <= w_busy_next;
      if (w_fire) begin
        r_out_valid     <= 1'b1;
        r_out_pc        <= io.in_pc;
        r_out_rs_val    <= w_rs_val;
        r_out_rt_val    <= w_rt_val;
        r_out_imm       <= {{(XLEN-16){io.in_instr[15]}}, io.in_instr[15:0]};
        r_out_op        <= w_op;
        r_out_funct     <= io.in_instr[5:0];
        r_out_dest      <= w_dest;
        r_out_reg_write <= w_reg_write;
        r_out_illegal   <= w_illegal;
      end else if (io.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign io.out_valid     = r_out_valid;
  assign io.out_pc        = r_out_pc;
  assign io.out_op        = r_out_op;
  assign io.out_rs_val    = r_out_rs_val;
  assign io.out_rt_val    = r_out_rt_val;
  assign io.out_imm       = r_out_imm;
  assign io.out_funct     = r_out_funct;
  assign io.out_dest      = r_out_dest;
  assign io.out_reg_write = r_out_reg_write;
  assign io.out_illegal   = r_out_illegal;
  assign io.busy_bits     = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_decode_issue_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_decode_issue_stage
// Purpose  : Directed self-checking bench for decode_issue_stage (both DECODE_WB_BYPASS_EN builds)
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_decode_issue_stage;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  logic [31:0] rf [32];

  decode_issue_if #(.XLEN(32), .NREGS(32)) bus ();

  decode_issue_stage #(.XLEN(32), .NREGS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: combinational read, write on the writeback strobe
  assign bus.rf_read_data_1 = rf[bus.rf_read_reg_1];
  assign bus.rf_read_data_2 = rf[bus.rf_read_reg_2];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
      rf[1] <= 32'd5;
      rf[2] <= 32'd7;
    end else if (bus.wb_en && bus.wb_reg != 5'd0) begin
      rf[bus.wb_reg] <= bus.wb_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return {6'h00, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_instr  = rtype(5'd1, 5'd2, 5'd3, 6'h20);
    bus.in_pc     = 32'h0;
    bus.out_ready = 1'b1;
    bus.wb_en     = 1'b1;
    bus.wb_reg    = 5'd3;
    bus.wb_data   = 32'd99;

    @(negedge clk);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    tick();
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.wb_en    = 1'b0;
    chk("rst_busy",      bus.busy_bits, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_pc",    bus.out_pc, 32'd0);
    chk("rst_rs_val",    bus.out_rs_val, 32'd0);
    chk("rst_rt_val",    bus.out_rt_val, 32'd0);
    chk("rst_imm",       bus.out_imm, 32'd0);
    chk("rst_fields",    {16'd0, bus.out_op, bus.out_funct, bus.out_dest,
                          bus.out_reg_write, bus.out_illegal}, 32'd0);

    // R-type add r3 = r1 + r2
    bus.in_valid = 1'b1;
    bus.in_instr = rtype(5'd1, 5'd2, 5'd3, 6'h20);
    bus.in_pc    = 32'h100;
    @(negedge clk);
    chk("add_in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    chk("add_valid",  {31'd0, bus.out_valid}, 32'd1);
    chk("add_op",     {29'd0, bus.out_op}, 32'd0);
    chk("add_dest",   {27'd0, bus.out_dest}, 32'd3);
    chk("add_rs_val", bus.out_rs_val, 32'd5);
    chk("add_rt_val", bus.out_rt_val, 32'd7);
    chk("add_funct",  {26'd0, bus.out_funct}, 32'h20);
    chk("add_pc",     bus.out_pc, 32'h100);
    chk("add_busy",   bus.busy_bits, 32'h8);

    // ADDI r9 = r3 - 4 stalls on r3 until writeback
    bus.in_instr = itype(6'h08, 5'd3, 5'd9, 16'hFFFC);
    bus.in_pc    = 32'h104;
    @(negedge clk);
    chk("raw_stall0", {31'd0, bus.in_ready}, 32'd0);
    tick();
    chk("drain_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("drain_hold",  {27'd0, bus.out_dest}, 32'd3);
    @(negedge clk);
    chk("raw_stall1", {31'd0, bus.in_ready}, 32'd0);
    tick();
    bus.wb_en   = 1'b1;
    bus.wb_reg  = 5'd3;
    bus.wb_data = 32'd42;
    @(negedge clk);
`ifdef DECODE_WB_BYPASS_EN
    chk("raw_wb_cycle", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.wb_en = 1'b0;
`else
    chk("raw_wb_cycle", {31'd0, bus.in_ready}, 32'd0);
    tick();
    bus.wb_en = 1'b0;
    @(negedge clk);
    chk("raw_after_wb", {31'd0, bus.in_ready}, 32'd1);
    tick();
`endif
    chk("addi_valid",  {31'd0, bus.out_valid}, 32'd1);
    chk("addi_op",     {29'd0, bus.out_op}, 32'd1);
    chk("addi_rs_val", bus.out_rs_val, 32'd42);
    chk("addi_imm",    bus.out_imm, 32'hFFFF_FFFC);
    chk("addi_dest",   {27'd0, bus.out_dest}, 32'd9);
    chk("addi_busy",   bus.busy_bits, 32'h200);

    bus.in_valid = 1'b0;
    bus.wb_en    = 1'b1;
    bus.wb_reg   = 5'd9;
    bus.wb_data  = 32'd1;
    tick();
    bus.wb_en = 1'b0;
    chk("clr9_busy", bus.busy_bits, 32'd0);

    // LW to r0 does not write; then an illegal opcode still issues
    bus.in_valid = 1'b1;
    bus.in_instr = itype(6'h23, 5'd1, 5'd0, 16'h0008);
    bus.in_pc    = 32'h108;
    tick();
    chk("lw0_op",   {29'd0, bus.out_op}, 32'd2);
    chk("lw0_wr",   {31'd0, bus.out_reg_write}, 32'd0);
    chk("lw0_busy", bus.busy_bits, 32'd0);
    bus.in_instr = itype(6'h3F, 5'd5, 5'd6, 16'h0000);
    bus.in_pc    = 32'h10C;
    tick();
    chk("ill_flag", {31'd0, bus.out_illegal}, 32'd1);
    chk("ill_op",   {29'd0, bus.out_op}, 32'd7);
    chk("ill_wr",   {31'd0, bus.out_reg_write}, 32'd0);

    // Back-pressure for three cycles, then replace the slot in one edge
    bus.out_ready = 1'b0;
    bus.in_instr  = rtype(5'd1, 5'd2, 5'd10, 6'h22);
    bus.in_pc     = 32'h200;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      tick();
      chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_pc",    bus.out_pc, 32'h10C);
      chk("bp_op",    {29'd0, bus.out_op}, 32'd7);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {31'd0, bus.in_ready}, 32'd1);
    tick();
    chk("rep_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("rep_pc",    bus.out_pc, 32'h200);
    chk("rep_dest",  {27'd0, bus.out_dest}, 32'd10);
    chk("rep_busy",  bus.busy_bits, 32'h400);

    // Same-cycle set and clear of r4
    bus.in_instr = itype(6'h08, 5'd0, 5'd4, 16'h0001);
    bus.in_pc    = 32'h300;
    tick();
    chk("r4_busy", bus.busy_bits, 32'h410);
    bus.in_pc   = 32'h304;
    bus.wb_en   = 1'b1;
    bus.wb_reg  = 5'd4;
    bus.wb_data = 32'd77;
    @(negedge clk);
`ifdef DECODE_WB_BYPASS_EN
    chk("waw_wb_cycle", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.wb_en = 1'b0;
`else
    chk("waw_wb_cycle", {31'd0, bus.in_ready}, 32'd0);
    tick();
    bus.wb_en = 1'b0;
    chk("waw_cleared", bus.busy_bits, 32'h400);
    @(negedge clk);
    chk("waw_after_wb", {31'd0, bus.in_ready}, 32'd1);
    tick();
`endif
    chk("waw_busy", bus.busy_bits, 32'h410);
    chk("waw_pc",   bus.out_pc, 32'h304);

    bus.in_valid = 1'b0;
    bus.wb_en    = 1'b1;
    bus.wb_reg   = 5'd4;
    tick();
    bus.wb_reg = 5'd10;
    tick();
    bus.wb_en = 1'b0;
    chk("clr_busy", bus.busy_bits, 32'd0);

    // Back-to-back independent ADDIs
    for (int k = 5; k <= 7; k++) begin
      bus.in_valid = 1'b1;
      bus.in_instr = itype(6'h08, 5'd0, 5'(k), 16'(k));
      bus.in_pc    = 32'h400 + 32'(4 * k);
      @(negedge clk);
      chk("b2b_in_ready", {31'd0, bus.in_ready}, 32'd1);
      tick();
      chk("b2b_dest", {27'd0, bus.out_dest}, 32'(k));
    end
    bus.in_valid = 1'b0;
    chk("b2b_busy", bus.busy_bits, 32'hE0);

    // Reset while stalled drops the held instruction
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = rtype(5'd1, 5'd2, 5'd11, 6'h20);
    @(negedge clk);
    chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_busy",  bus.busy_bits, 32'd0);
    chk("mid_rst_pc",    bus.out_pc, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
